uart_int_ctrl: RTL
==================

UART_INT_CTRL -- requirements
Module: uart_int_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have port ier, input, 4, interrupt enables: [0] RDA/CTI, [1] THRE, [2] line status, [3] modem status.
REQ-004 SHALL have port ier_wr, input, 1, pulse; ier carries the newly written value in the same cycle.
REQ-005 SHALL have port rx_ready, input, 1, level; receive data available or trigger level reached.
REQ-006 SHALL have port rx_timeout, input, 1, pulse; character timeout detected.
REQ-007 SHALL have port lsr_err, input, 1, pulse; overrun, parity, framing or break detected.
REQ-008 SHALL have port thr_empty, input, 1, level; transmit holding register or FIFO is empty.
REQ-009 SHALL have port msr_delta, input, 1, pulse; any modem-status delta bit set.
REQ-010 SHALL have ports rd_iir, rd_rbr, rd_lsr, rd_msr, wr_thr, input, 1 each, single-cycle host access strobes.
REQ-011 SHALL have port iir, output, 4, interrupt identification: bit0 = 1 means none pending; bits[3:1] = source ID.
REQ-012 SHALL have port irq, output, 1, interrupt request, active-high.

Function
REQ-013 SHALL keep four set/clear flags: ls_f, cti_f, thre_f, ms_f. Set SHALL win over clear in the same cycle.
REQ-014 ls_f SHALL be set by lsr_err and cleared by rd_lsr.
REQ-015 cti_f SHALL be set by rx_timeout and cleared by rd_rbr.
REQ-016 ms_f SHALL be set by msr_delta and cleared by rd_msr.
REQ-017 thre_f SHALL be set by a 0->1 transition of thr_empty, or by ier_wr with ier[1]=1 while thr_empty=1.
REQ-018 thre_f SHALL be cleared by wr_thr, or by rd_iir while registered iir = 4'b0010.
REQ-019 rda_f SHALL be registered every cycle as rx_ready.
REQ-020 Flags SHALL be set independent of ier; ier only gates the priority encode.
REQ-021 Priority encode, highest first, SHALL be:
  - ls_f&ier[2] -> 0110
  - rda_f&ier[0] -> 0100
  - cti_f&ier[0] -> 1100
  - thre_f&ier[1] -> 0010
  - ms_f&ier[3] -> 0000
  - none -> 0001
REQ-022 iir SHALL be registered from the encode every cycle; irq SHALL be registered as ~encode[0].
REQ-023 Latency: an event input in cycle N SHALL set its flag at edge N+1 and be visible on iir/irq after edge N+2.
REQ-024 A clear strobe in cycle N SHALL drop irq after edge N+2 if no other enabled source remains.
REQ-025 rd_iir SHALL only clear thre_f; it SHALL not affect other flags.
REQ-026 Disabling a source via ier SHALL remove it from iir within 1 cycle without clearing its flag; re-enabling SHALL re-expose it.
REQ-027 Simultaneous set and clear of the same flag SHALL leave it set.
REQ-028 Simultaneous events on different sources SHALL all be flagged; iir SHALL report them in priority order as higher ones clear.

Reset
REQ-029 When rst_n=0 at a rising edge, all flags SHALL be 0, iir SHALL be 4'b0001 and irq SHALL be 0.
REQ-030 The thr_empty edge-detect register SHALL reset to 1, so thr_empty=1 out of reset raises no THRE interrupt without ier_wr.
REQ-031 Reset asserted mid-operation SHALL override all set and clear strobes in that cycle.

Structure
REQ-032 Package uart_int_pkg SHALL hold the IIR code constants (NONE, LS, RDA, CTI, THRE, MS) and the IER bit indices.
REQ-033 The set-dominant, synchronous-reset flag SHALL be sub-module uart_int_flag, instantiated four times.
REQ-034 The block SHALL be pure RTL: no latches, no combinational outputs.

Verification
REQ-035 Reset test: rst_n=0 for 2 cycles with every input at 1 -> iir=0001, irq=0. Release with thr_empty=1 and ier=0010, no ier_wr -> iir stays 0001.
REQ-036 Priority test: ier=1111; pulse lsr_err, rx_timeout and msr_delta in one cycle -> iir=0110.
  - rd_lsr -> iir=1100.
  - rd_rbr -> iir=0000.
  - rd_msr -> iir=0001, irq=0; each step 2 cycles after its strobe.
REQ-037 THRE test: thr_empty=1, ier_wr with ier=0010 -> iir=0010 after 2 cycles. rd_iir -> iir=0001. Later thr_empty 1->0->1 -> iir=0010 again.
REQ-038 Set-wins test: ier=1000; msr_delta and rd_msr in the same cycle -> ms_f=1, iir=0000.
REQ-039 Masking test: ier=0000; pulse lsr_err -> irq=0. Write ier=0100 -> iir=0110 1 cycle later.
REQ-040 Reset mid-operation: all flags set with irq=1; rst_n=0 for 1 cycle -> iir=0001, irq=0 after that edge.

Source files
------------

// File: rtl/uart_int_pkg.sv
// rtl/uart_int_pkg.sv - IIR codes, IER bit indices and the interrupt priority encoder
// Purpose: shared constants and the priority encode used by uart_int_ctrl.
// Ports: none (package).
package uart_int_pkg;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_LS   = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_MS   = 4'b0000;

  localparam int IER_RDA  = 0;
  localparam int IER_THRE = 1;
  localparam int IER_LS   = 2;
  localparam int IER_MS   = 3;

  typedef struct packed {
    logic ls;
    logic rda;
    logic cti;
    logic thre;
    logic ms;
  } int_flags_t;

  // Highest-priority enabled source wins; CTI shares the RDA enable bit.
  function automatic logic [3:0] iir_encode(input int_flags_t f, input logic [3:0] ier);
    if (f.ls && ier[IER_LS])              return IIR_LS;
    else if (f.rda && ier[IER_RDA])       return IIR_RDA;
    else if (f.cti && ier[IER_RDA])       return IIR_CTI;
    else if (f.thre && ier[IER_THRE])     return IIR_THRE;
    else if (f.ms && ier[IER_MS])         return IIR_MS;
    else                                  return IIR_NONE;
  endfunction

endpackage

// File: rtl/uart_int_flag.sv
// rtl/uart_int_flag.sv - set-dominant sticky interrupt flag
// Purpose: one interrupt-pending bit; set beats clear when both arrive together.
// Ports: clk, rst_n (sync, active-low), set, clr (strobes), q (flag state).
module uart_int_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n)   q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end

endmodule

// File: rtl/uart_int_ctrl.sv
// rtl/uart_int_ctrl.sv - UART interrupt flag tracking, priority encode and IIR/IRQ generation
// Purpose: latches UART interrupt events, masks them with IER and reports the
//   highest-priority pending source on a registered IIR and IRQ.
// Ports: clk, rst_n (sync, active-low); ier[3:0] + ier_wr (enable write);
//   rx_ready, thr_empty (levels); rx_timeout, lsr_err, msr_delta (event pulses);
//   rd_iir, rd_rbr, rd_lsr, rd_msr, wr_thr (host access strobes);
//   iir[3:0] (bit0=1 none pending, [3:1] source ID), irq (active-high request).
module uart_int_ctrl
  import uart_int_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ier,
  input  logic       ier_wr,
  input  logic       rx_ready,
  input  logic       rx_timeout,
  input  logic       lsr_err,
  input  logic       thr_empty,
  input  logic       msr_delta,
  input  logic       rd_iir,
  input  logic       rd_rbr,
  input  logic       rd_lsr,
  input  logic       rd_msr,
  input  logic       wr_thr,
  output logic [3:0] iir,
  output logic       irq
);

  logic       ls_f, cti_f, thre_f, ms_f, rda_f;
  logic       thr_empty_q;
  logic       thre_set, thre_clr;
  int_flags_t flags;
  logic [3:0] code;

  // Edge register resets to 1 so an already-empty THR out of reset is not an event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_empty_q <= 1'b1;
      rda_f       <= 1'b0;
    end else begin
      thr_empty_q <= thr_empty;
      rda_f       <= rx_ready;
    end
  end

  // Enabling THRE while the THR is already empty raises the interrupt immediately.
  assign thre_set = (thr_empty && !thr_empty_q) || (ier_wr && ier[IER_THRE] && thr_empty);
  // Reading IIR acknowledges THRE only when THRE is what IIR is currently reporting.
  assign thre_clr = wr_thr || (rd_iir && (iir == IIR_THRE));

  uart_int_flag u_ls_flag   (.clk(clk), .rst_n(rst_n), .set(lsr_err),    .clr(rd_lsr),   .q(ls_f));
  uart_int_flag u_cti_flag  (.clk(clk), .rst_n(rst_n), .set(rx_timeout), .clr(rd_rbr),   .q(cti_f));
  uart_int_flag u_thre_flag (.clk(clk), .rst_n(rst_n), .set(thre_set),   .clr(thre_clr), .q(thre_f));
  uart_int_flag u_ms_flag   (.clk(clk), .rst_n(rst_n), .set(msr_delta),  .clr(rd_msr),   .q(ms_f));

  always_comb begin
    flags      = '0;
    flags.ls   = ls_f;
    flags.rda  = rda_f;
    flags.cti  = cti_f;
    flags.thre = thre_f;
    flags.ms   = ms_f;
    code       = iir_encode(flags, ier);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iir <= IIR_NONE;
      irq <= 1'b0;
    end else begin
      iir <= code;
      irq <= ~code[0];
    end
  end

endmodule
